// File: rtl/bcd_digit_check_pipe.sv
// bcd_digit_check_pipe: two-stage valid/ready pipeline that flags every 4-bit digit above LIMIT,
// emits the digit reduced by LIMIT+1 (mod 16, no inter-digit carry), and keeps a saturating
// count of delivered words that carried at least one flagged digit.
// Optional feature: define BCD_CHECK_STICKY_EN to add the sticky_flag output, a per-digit
// record of flags seen on delivered words, cleared by clr or reset_n.
module bcd_digit_check_pipe #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned LIMIT     = 9,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_flag,
  output logic                  out_err,
  output logic [ERR_CNT_W-1:0]  err_count
`ifdef BCD_CHECK_STICKY_EN
  ,
  output logic [DIGITS-1:0]     sticky_flag
`endif
);

  localparam logic [3:0]           LimD   = 4'(LIMIT);
  localparam logic [3:0]           LimP1  = 4'(LIMIT + 1);
  localparam logic [ERR_CNT_W-1:0] CntMax = '1;

  // Holds in_ready low until the first edge after reset release.
  logic ready_en_q, ready_en_d;

  // Stage 1: raw digits plus compare flags.
  logic                s1_valid_q, s1_valid_d;
  logic [4*DIGITS-1:0] s1_data_q, s1_data_d;
  logic [DIGITS-1:0]   s1_flag_q, s1_flag_d;

  // Stage 2: corrected digits, flags and error summary (drives the outputs directly).
  logic                s2_valid_q, s2_valid_d;
  logic [4*DIGITS-1:0] s2_data_q, s2_data_d;
  logic [DIGITS-1:0]   s2_flag_q, s2_flag_d;
  logic                s2_err_q, s2_err_d;

  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                s2_ready, s1_ready;
  logic                in_fire, s1_move, out_fire;
  logic [DIGITS-1:0]   in_flag;
  logic [4*DIGITS-1:0] s1_corr;

  // Handshake: each stage loads when empty or when its contents leave in the same cycle.
  always_comb begin
    s2_ready   = !s2_valid_q || out_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    in_ready   = ready_en_q && s1_ready;
    in_fire    = in_valid && in_ready;
    s1_move    = s1_valid_q && s2_ready;
    out_fire   = s2_valid_q && out_ready;
    ready_en_d = 1'b1;
  end

  // Per-digit compare on the incoming word and correction on the stage-1 word.
  always_comb begin
    in_flag = '0;
    s1_corr = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      in_flag[i]      = in_data[4*i +: 4] > LimD;
      s1_corr[4*i +: 4] = s1_flag_q[i] ? (s1_data_q[4*i +: 4] - LimP1) : s1_data_q[4*i +: 4];
    end
  end

  // Stage 1 next state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_flag_d  = s1_flag_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_flag_d  = in_flag;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state; contents held while out_valid=1 and out_ready=0.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flag_d  = s2_flag_q;
    s2_err_d   = s2_err_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_corr;
      s2_flag_d  = s1_flag_q;
      s2_err_d   = |s1_flag_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // Saturating error-word counter; clr beats a same-cycle increment.
  always_comb begin
    err_count_d = err_count_q;
    if (clr) begin
      err_count_d = '0;
    end else if (out_fire && s2_err_q && (err_count_q != CntMax)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_flag_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_flag_q   <= '0;
      s2_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      ready_en_q  <= ready_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_flag_q   <= s1_flag_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_flag_q   <= s2_flag_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef BCD_CHECK_STICKY_EN
  logic [DIGITS-1:0] sticky_q, sticky_d;

  // Accumulate flags of delivered words; clr beats a same-cycle set.
  always_comb begin
    sticky_d = sticky_q;
    if (clr) begin
      sticky_d = '0;
    end else if (out_fire) begin
      sticky_d = sticky_q | s2_flag_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flag = sticky_q;
`endif

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flag  = s2_flag_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_bcd_digit_check_pipe.sv
// Scoreboard bench for bcd_digit_check_pipe (DIGITS=4, LIMIT=9, ERR_CNT_W=2).
module tb_bcd_digit_check_pipe;

  localparam logic [1:0] CntMax = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_flag;
  logic        out_err;
  logic [1:0]  err_count;
`ifdef BCD_CHECK_STICKY_EN
  logic [3:0]  sticky_flag;
`endif

  bcd_digit_check_pipe #(
    .DIGITS   (4),
    .LIMIT    (9),
    .ERR_CNT_W(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flag   (out_flag),
    .out_err    (out_err),
    .err_count  (err_count)
`ifdef BCD_CHECK_STICKY_EN
    ,
    .sticky_flag(sticky_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  f;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   waits = 0;

  logic [1:0]  exp_cnt;
  logic [3:0]  exp_sticky;
  logic        prev_hold;
  logic [15:0] prev_d;
  logic [3:0]  prev_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Offer one word; expected response pushed at the accepting edge.
  task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic [3:0] ef);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
      waits++;
    end
    if (got) begin
      q.push_back('{d: ed, f: ef, e: |ef});
      acc_cnt++;
    end else begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: pops on every output transfer, checks hold stability and the counter model.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q.delete();
      exp_cnt    = '0;
      exp_sticky = '0;
      prev_hold  = 1'b0;
    end else begin
      check("err_count", 32'(err_count), 32'(exp_cnt));
`ifdef BCD_CHECK_STICKY_EN
      check("sticky_flag", 32'(sticky_flag), 32'(exp_sticky));
`endif
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_d));
        check("hold_flag", 32'(out_flag), 32'(prev_f));
      end
      e = '0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_flag", 32'(out_flag), 32'(e.f));
          check("out_err", 32'(out_err), 32'(e.e));
        end
      end
      if (clr) begin
        exp_cnt    = '0;
        exp_sticky = '0;
      end else begin
        if (e.e && exp_cnt != CntMax) exp_cnt = exp_cnt + 2'd1;
        exp_sticky = exp_sticky | e.f;
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
      prev_f    = out_flag;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values.
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flag", 32'(out_flag), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Legal digits pass through; then a mixed word.
    send(16'h9999, 16'h9999, 4'b0000);
    drain();
    send(16'hF0A9, 16'h5009, 4'b1010);
    drain();
    check("t2_err_count", 32'(err_count), 32'd1);

    // Back-to-back burst at full throughput.
    waits = 0;
    send(16'h0000, 16'h0000, 4'b0000);
    send(16'h1234, 16'h1234, 4'b0000);
    send(16'hABCD, 16'h0123, 4'b1111);
    send(16'h9A9A, 16'h9090, 4'b0101);
    send(16'hFFFF, 16'h5555, 4'b1111);
    send(16'h5AF0, 16'h5050, 4'b0110);
    send(16'h8B7C, 16'h8172, 4'b0101);
    send(16'hE0D9, 16'h4039, 4'b1010);
    check("t3_no_stall", 32'(waits), 32'd0);
    drain();

    // Backpressure: two words fit, third waits until out_ready returns.
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(16'h1111, 16'h1111, 4'b0000);
        send(16'h2B22, 16'h2122, 4'b0100);
        send(16'h3333, 16'h3333, 4'b0000);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_accepted", 32'(acc_cnt - base), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturation of a 2-bit counter.
    pulse_clr();
    for (int i = 0; i < 5; i++) send(16'h000A, 16'h0000, 4'b0001);
    drain();
    check("t5_sat", 32'(err_count), 32'd3);
    // clr coincident with an increment.
    send(16'h000A, 16'h0000, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("t5_out_valid", 32'(out_valid), 32'd1);
    pulse_clr();
    check("t5_clr_wins", 32'(err_count), 32'd0);
    check("t5_popped", 32'(q.size()), 32'd0);

`ifdef BCD_CHECK_STICKY_EN
    send(16'h000A, 16'h0000, 4'b0001);
    send(16'h1234, 16'h1234, 4'b0000);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("sticky_persist", 32'(sticky_flag), 32'd1);
    pulse_clr();
    check("sticky_clr", 32'(sticky_flag), 32'd0);
`endif

    // Reset with two words in flight.
    send(16'h00B0, 16'h0010, 4'b0010);
    drain();
    check("t6_pre_cnt", 32'(err_count), 32'd1);
    send(16'h000A, 16'h0000, 4'b0001);
    send(16'h00A0, 16'h0000, 4'b0010);
    check("t6_inflight", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_data", 32'(out_data), 32'd0);
    check("t6_async_flag", 32'(out_flag), 32'd0);
    check("t6_async_cnt", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_stale", 32'(out_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    send(16'h5555, 16'h5555, 4'b0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
